// File: rtl/arb_pkg.sv
// Shared types for the unified memory port arbiter: FSM states, owner
// encoding, streak counter width and a saturating increment helper.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_GNT = 2'd1,
        WAIT_RSP = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } arb_owner_t;

    // Streak limit range is 1..15, so four bits hold every legal value.
    localparam int STREAK_W = 4;

    // Increment that never climbs past the supplied ceiling.
    function automatic logic [STREAK_W-1:0] streak_inc_sat(
        input logic [STREAK_W-1:0] cnt,
        input logic [STREAK_W-1:0] ceil_v
    );
        logic [STREAK_W-1:0] res;
        if (cnt >= ceil_v) begin
            res = cnt;
        end else begin
            res = cnt + 4'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/arb_streak_ctr.sv
// Saturating count of consecutive D grants taken while fetch was waiting.
// o_at_max tells the arbiter that fetch must win the next contested grant.
module arb_streak_ctr
    import arb_pkg::*;
#(
    parameter int MAX_STREAK = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_at_max
);

    localparam logic [STREAK_W-1:0] LP_MAX = STREAK_W'(MAX_STREAK);

    logic [STREAK_W-1:0] r_cnt;

    // Streak register: clear wins over increment, increment saturates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= {STREAK_W{1'b0}};
        end else if (i_clr) begin
            r_cnt <= {STREAK_W{1'b0}};
        end else if (i_inc) begin
            r_cnt <= streak_inc_sat(r_cnt, LP_MAX);
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_at_max = (r_cnt == LP_MAX);

endmodule

// File: rtl/mem_port_arbiter.sv
// Non-pipelined arbiter sharing one memory port between instruction fetch (I)
// and load/store (D). D has priority; a streak limit guarantees fetch progress.
// Optional feature macro: ARB_TIMEOUT_EN (watchdog abort + sticky err flag).
module mem_port_arbiter
    import arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MAX_STREAK = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_req,
    input  logic [ADDR_W-1:0]     i_addr,
    output logic                  i_gnt,
    output logic                  i_rvalid,
    output logic [DATA_W-1:0]     i_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [DATA_W/8-1:0]   d_be,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_W-1:0]     d_rdata,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_W/8-1:0]   mem_be,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  err
);

    localparam int BE_W = DATA_W / 8;

    arb_state_t          r_state;
    arb_state_t          w_state_nxt;
    arb_owner_t          r_owner;
    logic                w_grant_i;
    logic                w_grant_d;
    logic                w_streak_inc;
    logic                w_streak_clr;
    logic                w_at_max;
    logic                w_timeout;
    logic                r_mem_req;
    logic                r_mem_we;
    logic [BE_W-1:0]     r_mem_be;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic                r_i_rvalid;
    logic                r_d_rvalid;
    logic [DATA_W-1:0]   r_i_rdata;
    logic [DATA_W-1:0]   r_d_rdata;

`ifdef ARB_TIMEOUT_EN
    logic [7:0] r_wdog;
    logic       r_err;

    // Abort fires on the TIMEOUT-th cycle spent waiting on memory.
    assign w_timeout = (r_state != IDLE) && (r_wdog == 8'(TIMEOUT - 1));

    // Watchdog: restarts in IDLE, counts every cycle spent waiting on memory.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wdog <= 8'd0;
        end else if (r_state == IDLE) begin
            r_wdog <= 8'd0;
        end else begin
            r_wdog <= r_wdog + 8'd1;
        end
    end

    // Sticky error flag, only cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_timeout) begin
            r_err <= 1'b1;
        end else begin
            r_err <= r_err;
        end
    end

    assign err = r_err;
`else
    logic w_unused_timeout;

    assign w_timeout        = 1'b0;
    assign w_unused_timeout = ^{1'b0, 8'(TIMEOUT)};
    assign err              = 1'b0;
`endif

    // Next-state and grant decision; grants are only ever issued from IDLE.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_i   = 1'b0;
        w_grant_d   = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_req && (!d_req || w_at_max)) begin
                    w_grant_i   = 1'b1;
                    w_state_nxt = WAIT_GNT;
                end else if (d_req) begin
                    w_grant_d   = 1'b1;
                    w_state_nxt = WAIT_GNT;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            WAIT_GNT: begin
                if (w_timeout) begin
                    w_state_nxt = IDLE;
                end else if (mem_gnt) begin
                    w_state_nxt = WAIT_RSP;
                end else begin
                    w_state_nxt = WAIT_GNT;
                end
            end
            WAIT_RSP: begin
                if (w_timeout || mem_rvalid) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = WAIT_RSP;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A contested D grant extends the streak; any other grant resets it.
    assign w_streak_inc = w_grant_d && i_req;
    assign w_streak_clr = w_grant_i || (w_grant_d && !i_req);

    arb_streak_ctr #(
        .MAX_STREAK (MAX_STREAK)
    ) u_streak (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_inc    (w_streak_inc),
        .i_clr    (w_streak_clr),
        .o_at_max (w_at_max)
    );

    // Memory request registers: capture the winner, hold until memory accepts.
    // Fetches are full-word reads, so all byte enables are set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_be    <= {BE_W{1'b0}};
            r_mem_addr  <= {ADDR_W{1'b0}};
            r_mem_wdata <= {DATA_W{1'b0}};
            r_owner     <= OWN_I;
        end else if (w_grant_i) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b0;
            r_mem_be    <= {BE_W{1'b1}};
            r_mem_addr  <= i_addr;
            r_mem_wdata <= {DATA_W{1'b0}};
            r_owner     <= OWN_I;
        end else if (w_grant_d) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= d_we;
            r_mem_be    <= d_be;
            r_mem_addr  <= d_addr;
            r_mem_wdata <= d_wdata;
            r_owner     <= OWN_D;
        end else if ((r_state == WAIT_GNT) && (mem_gnt || w_timeout)) begin
            r_mem_req   <= 1'b0;
        end else begin
            r_mem_req   <= r_mem_req;
        end
    end

    // Response steering: one-cycle rvalid to the owner; rdata holds between pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_i_rvalid <= 1'b0;
            r_d_rvalid <= 1'b0;
            r_i_rdata  <= {DATA_W{1'b0}};
            r_d_rdata  <= {DATA_W{1'b0}};
        end else begin
            r_i_rvalid <= 1'b0;
            r_d_rvalid <= 1'b0;
            if (w_timeout) begin
                if (r_owner == OWN_D) begin
                    r_d_rvalid <= 1'b1;
                    r_d_rdata  <= {DATA_W{1'b0}};
                end else begin
                    r_i_rvalid <= 1'b1;
                    r_i_rdata  <= {DATA_W{1'b0}};
                end
            end else if ((r_state == WAIT_RSP) && mem_rvalid) begin
                if (r_owner == OWN_D) begin
                    r_d_rvalid <= 1'b1;
                    r_d_rdata  <= mem_rdata;
                end else begin
                    r_i_rvalid <= 1'b1;
                    r_i_rdata  <= mem_rdata;
                end
            end else begin
                r_i_rdata  <= r_i_rdata;
                r_d_rdata  <= r_d_rdata;
            end
        end
    end

    assign i_gnt     = w_grant_i;
    assign d_gnt     = w_grant_d;
    assign i_rvalid  = r_i_rvalid;
    assign i_rdata   = r_i_rdata;
    assign d_rvalid  = r_d_rvalid;
    assign d_rdata   = r_d_rdata;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_be    = r_mem_be;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a table of single transactions plus
// hand-written sequences for starvation, mid-transaction reset and timeout.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_gnt;
    logic        i_rvalid;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        err;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] m_i_rdata;
    logic [31:0] m_d_rdata;

    typedef struct {
        logic        i_req;
        logic        d_req;
        logic        d_we;
        logic [3:0]  d_be;
        logic [31:0] i_addr;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        int          gnt_cyc;
        int          rsp_cyc;
        logic [31:0] rdata;
        logic        exp_i_gnt;
        logic        exp_d_gnt;
        logic        exp_we;
        logic [3:0]  exp_be;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
    } vec_t;

    vec_t vecs[6];
    vec_t pv;

    mem_port_arbiter #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .MAX_STREAK (4),
        .TIMEOUT    (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_req      (i_req),
        .i_addr     (i_addr),
        .i_gnt      (i_gnt),
        .i_rvalid   (i_rvalid),
        .i_rdata    (i_rdata),
        .d_req      (d_req),
        .d_we       (d_we),
        .d_be       (d_be),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_gnt      (d_gnt),
        .d_rvalid   (d_rvalid),
        .d_rdata    (d_rdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_be     (mem_be),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%b expected=%b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // One transaction starting in an IDLE cycle, at its negedge.
    task automatic run_vec(input vec_t v);
        i_req   = v.i_req;
        d_req   = v.d_req;
        d_we    = v.d_we;
        d_be    = v.d_be;
        i_addr  = v.i_addr;
        d_addr  = v.d_addr;
        d_wdata = v.d_wdata;
        #1;
        chk1("i_gnt", i_gnt, v.exp_i_gnt);
        chk1("d_gnt", d_gnt, v.exp_d_gnt);
        @(negedge clk);
        if (v.exp_i_gnt) i_req = 1'b0;
        else             d_req = 1'b0;
        #1;
        chk1("gnt_outside_idle", i_gnt | d_gnt, 1'b0);
        chk1("rvalid_one_cycle", i_rvalid | d_rvalid, 1'b0);
        chk1("mem_req_issue", mem_req, 1'b1);
        chk1("mem_we", mem_we, v.exp_we);
        chk32("mem_addr", mem_addr, v.exp_addr);
        if (v.exp_d_gnt) begin
            chk32("mem_be", 32'(mem_be), 32'(v.exp_be));
            chk32("mem_wdata", mem_wdata, v.exp_wdata);
        end
        for (int c = 1; c < v.gnt_cyc; c++) begin
            @(negedge clk);
            #1;
            chk1("mem_req_hold", mem_req, 1'b1);
            chk32("mem_addr_hold", mem_addr, v.exp_addr);
        end
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        #1;
        chk1("mem_req_drop", mem_req, 1'b0);
        for (int c = v.gnt_cyc + 1; c < v.rsp_cyc; c++) begin
            @(negedge clk);
            #1;
            chk1("no_early_rvalid", i_rvalid | d_rvalid, 1'b0);
        end
        mem_rvalid = 1'b1;
        mem_rdata  = v.rdata;
        @(negedge clk);
        mem_rvalid = 1'b0;
        mem_rdata  = 32'hA5A5_5A5A;
        if (v.exp_i_gnt) m_i_rdata = v.rdata;
        else             m_d_rdata = v.rdata;
        #1;
        chk1("i_rvalid", i_rvalid, v.exp_i_gnt);
        chk1("d_rvalid", d_rvalid, v.exp_d_gnt);
        chk32("i_rdata", i_rdata, m_i_rdata);
        chk32("d_rdata", d_rdata, m_d_rdata);
    endtask

    // Global time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "bench time limit exceeded");
    end

    initial begin
        logic [6:0] exp_d_pat;

        //        i_req d_req we    be       i_addr        d_addr        wdata         gc rc rdata          eI    eD    eWe   eBe      eAddr         eWdata
        vecs[0] = '{1'b0, 1'b1, 1'b0, 4'b1111, 32'h0000_0000, 32'h0000_0100, 32'h0000_0000, 2, 4, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0, 4'b1111, 32'h0000_0100, 32'h0000_0000};
        vecs[1] = '{1'b0, 1'b1, 1'b1, 4'b0011, 32'h0000_0000, 32'h0000_0200, 32'h0000_1234, 1, 2, 32'hCAFE_0001, 1'b0, 1'b1, 1'b1, 4'b0011, 32'h0000_0200, 32'h0000_1234};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 4'b0000, 32'h0000_1000, 32'h0000_0000, 32'h0000_0000, 1, 2, 32'h0000_0013, 1'b1, 1'b0, 1'b0, 4'b0000, 32'h0000_1000, 32'h0000_0000};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 4'b1111, 32'h0000_1004, 32'h0000_0300, 32'h0000_0000, 3, 6, 32'h0BAD_F00D, 1'b0, 1'b1, 1'b0, 4'b1111, 32'h0000_0300, 32'h0000_0000};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 4'b0000, 32'h0000_1004, 32'h0000_0000, 32'h0000_0000, 1, 3, 32'h0000_0093, 1'b1, 1'b0, 1'b0, 4'b0000, 32'h0000_1004, 32'h0000_0000};
        vecs[5] = '{1'b0, 1'b1, 1'b1, 4'b1100, 32'h0000_0000, 32'h0000_0204, 32'hFFFF_0000, 1, 2, 32'h0000_0000, 1'b0, 1'b1, 1'b1, 4'b1100, 32'h0000_0204, 32'hFFFF_0000};
        pv      = '{1'b1, 1'b0, 1'b0, 4'b0000, 32'h0000_2040, 32'h0000_0000, 32'h0000_0000, 1, 2, 32'h1111_2222, 1'b1, 1'b0, 1'b0, 4'b0000, 32'h0000_2040, 32'h0000_0000};

        rst_n      = 1'b0;
        i_req      = 1'b0;
        i_addr     = 32'h0;
        d_req      = 1'b0;
        d_we       = 1'b0;
        d_be       = 4'h0;
        d_addr     = 32'h0;
        d_wdata    = 32'h0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        m_i_rdata  = 32'h0;
        m_d_rdata  = 32'h0;

        // Reset state.
        #2;
        chk1("rst_mem_req", mem_req, 1'b0);
        chk32("rst_mem_addr", mem_addr, 32'h0);
        chk1("rst_rvalid", i_rvalid | d_rvalid, 1'b0);
        chk32("rst_d_rdata", d_rdata, 32'h0);
        chk1("rst_err", err, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Table: load, store, fetch, contested D, fetch in D's rvalid cycle, store.
        for (int k = 0; k < 6; k++) begin
            run_vec(vecs[k]);
        end

        // Starvation: both requesters held, fast memory; streak is 0 here.
        exp_d_pat = 7'b1101111;
        i_req  = 1'b1;
        i_addr = 32'h0000_2000;
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_be   = 4'b1111;
        d_addr = 32'h0000_0400;
        for (int g = 0; g < 7; g++) begin
            #1;
            chk1("starve_d_gnt", d_gnt, exp_d_pat[g]);
            chk1("starve_i_gnt", i_gnt, ~exp_d_pat[g]);
            @(negedge clk);
            mem_gnt = 1'b1;
            @(negedge clk);
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b1;
            mem_rdata  = 32'h0000_0100 + 32'(g);
            @(negedge clk);
            mem_rvalid = 1'b0;
            if (exp_d_pat[g]) m_d_rdata = 32'h0000_0100 + 32'(g);
            else              m_i_rdata = 32'h0000_0100 + 32'(g);
            #1;
            chk1("starve_d_rvalid", d_rvalid, exp_d_pat[g]);
            chk1("starve_i_rvalid", i_rvalid, ~exp_d_pat[g]);
            chk32("starve_i_rdata", i_rdata, m_i_rdata);
            chk32("starve_d_rdata", d_rdata, m_d_rdata);
        end
        i_req = 1'b0;
        d_req = 1'b0;

        // Reset while waiting for the response.
        @(negedge clk);
        d_req  = 1'b1;
        d_we   = 1'b1;
        d_be   = 4'b0101;
        d_addr = 32'h0000_0500;
        #1;
        chk1("rstseq_d_gnt", d_gnt, 1'b1);
        @(negedge clk);
        d_req   = 1'b0;
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        #2;
        rst_n = 1'b0;
        m_i_rdata = 32'h0;
        m_d_rdata = 32'h0;
        #1;
        chk1("async_rst_mem_req", mem_req, 1'b0);
        chk1("async_rst_mem_we", mem_we, 1'b0);
        chk32("async_rst_mem_be", 32'(mem_be), 32'h0);
        chk32("async_rst_mem_addr", mem_addr, 32'h0);
        chk32("async_rst_mem_wdata", mem_wdata, 32'h0);
        chk1("async_rst_rvalid", i_rvalid | d_rvalid, 1'b0);
        chk32("async_rst_i_rdata", i_rdata, 32'h0);
        chk32("async_rst_d_rdata", d_rdata, 32'h0);
        chk1("async_rst_gnt", i_gnt | d_gnt, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk1("no_stale_rvalid", i_rvalid | d_rvalid, 1'b0);
        run_vec(pv);

`ifdef ARB_TIMEOUT_EN
        // Memory never grants: abort after 8 waiting cycles.
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_be   = 4'b1111;
        d_addr = 32'h0000_0600;
        #1;
        chk1("to_d_gnt", d_gnt, 1'b1);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            d_req = 1'b0;
            #1;
            chk1("to_mem_req_high", mem_req, 1'b1);
            chk1("to_no_rvalid", d_rvalid, 1'b0);
        end
        @(negedge clk);
        #1;
        chk1("to_mem_req_drop", mem_req, 1'b0);
        chk1("to_d_rvalid", d_rvalid, 1'b1);
        chk32("to_d_rdata", d_rdata, 32'h0);
        chk1("to_err_set", err, 1'b1);
        repeat (3) @(negedge clk);
        #1;
        chk1("to_err_sticky", err, 1'b1);
        chk1("to_rvalid_single", d_rvalid, 1'b0);
`else
        chk1("err_tied_low", err, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
